// File: rtl/drive_pkg.sv
// Shared types for the drive sequencer: FSM states, speed codes, junction commands
// and the per-motor drive word, plus the fixed drive patterns.
package drive_pkg;

  typedef enum logic [2:0] {
    ST_FOLLOW    = 3'd0,
    ST_COLLISION = 3'd1,
    ST_JWAIT     = 3'd2,
    ST_DEADTIME  = 3'd3,
    ST_MANEUVER  = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_STOP     = 3'd1,
    CMD_STRAIGHT = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_RIGHT    = 3'd4,
    CMD_REVERSE  = 3'd5
  } cmd_t;

  localparam logic [1:0] SPD_OFF  = 2'b00;
  localparam logic [1:0] SPD_VEER = 2'b01;
  localparam logic [1:0] SPD_FULL = 2'b10;

  typedef struct packed {
    logic [1:0] left_speed;
    logic       left_rev;
    logic [1:0] right_speed;
    logic       right_rev;
  } drive_t;

  function automatic cmd_t band_to_cmd(input logic [4:0] band);
    cmd_t c;
    case (band)
      5'b00001: c = CMD_STOP;
      5'b00010: c = CMD_STRAIGHT;
      5'b00100: c = CMD_LEFT;
      5'b01000: c = CMD_RIGHT;
      5'b10000: c = CMD_REVERSE;
      default:  c = CMD_NONE;
    endcase
    return c;
  endfunction

  function automatic drive_t follow_pattern(input logic [1:0] sel);
    drive_t d;
    d = '0;
    case (sel)
      2'b00: begin d.left_speed = SPD_FULL; d.right_speed = SPD_FULL; end
      2'b01: begin d.left_speed = SPD_VEER; d.right_speed = SPD_FULL; end
      2'b10: begin d.left_speed = SPD_FULL; d.right_speed = SPD_VEER; end
      default: begin d.left_speed = SPD_OFF; d.right_speed = SPD_OFF; end
    endcase
    return d;
  endfunction

  function automatic drive_t maneuver_pattern(input cmd_t c);
    drive_t d;
    d = '0;
    case (c)
      CMD_STRAIGHT: begin d.left_speed = SPD_FULL; d.right_speed = SPD_FULL; end
      CMD_LEFT:     begin d.left_speed = SPD_OFF;  d.right_speed = SPD_FULL; end
      CMD_RIGHT:    begin d.left_speed = SPD_FULL; d.right_speed = SPD_OFF;  end
      CMD_REVERSE: begin
        d.left_speed  = SPD_FULL;
        d.right_speed = SPD_FULL;
        d.left_rev    = 1'b1;
        d.right_rev   = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tone_qualifier.sv
// Debounces the tone band outputs: valid when bp is one-hot and unchanged for DEBOUNCE_CYCLES
// consecutive cycles (combinational on the qualifying cycle). No backpressure; clear zeroes the run.
module tone_qualifier
  import drive_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [4:0] bp,
  output logic       valid,
  output cmd_t       cmd
);

  localparam logic [CNT_W-1:0] L_DEB = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  logic [4:0]       r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_run;
  logic             w_onehot;
  logic             w_hit;

  // w_run is the length of the one-hot run including the current cycle.
  always_comb begin
    w_onehot = (bp != 5'd0) && ((bp & (bp - 5'd1)) == 5'd0);
    w_run    = '0;
    if (w_onehot) begin
      w_run = (bp == r_prev) ? (r_cnt + L_ONE) : L_ONE;
    end
    w_hit = (w_run >= L_DEB);
    valid = !clear && w_hit;
    cmd   = valid ? band_to_cmd(bp) : CMD_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= bp;
      r_cnt  <= w_hit ? L_DEB : w_run;
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// Arbitrates collision > junction tone command > line following and times manoeuvres/dead time.
// One cycle from input sample to registered outputs; no backpressure.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 500_000,
  parameter int TONE_TIMEOUT_CYCLES = 150_000_000,
  parameter int MANEUVER_CYCLES     = 25_000_000,
  parameter int DEADTIME_CYCLES     = 50_000,
  parameter int CNT_W               = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir,
  input  logic       col_detect,
  input  logic       junction,
  input  logic [4:0] bp,
  output logic [1:0] left_speed,
  output logic       left_rev,
  output logic [1:0] right_speed,
  output logic       right_rev,
  output logic [2:0] state,
  output logic [2:0] last_cmd
);

  localparam logic [CNT_W-1:0] L_TO_LAST  = CNT_W'(TONE_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_MAN_LAST = CNT_W'(MANEUVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_DT_LAST  = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

  state_t           r_state;
  state_t           r_ret;
  cmd_t             r_mcmd;
  cmd_t             r_last;
  logic [CNT_W-1:0] r_timer;
  logic             r_junc_d;
  drive_t           r_drv;

  state_t w_nxt_state;
  state_t w_nxt_ret;
  cmd_t   w_nxt_mcmd;
  cmd_t   w_nxt_last;
  drive_t w_nxt_drv;
  logic   w_junc_rise;
  logic   w_timer_run;
  logic   w_tone_vld;
  cmd_t   w_tone_cmd;
  logic   w_unused_dir;

  assign w_unused_dir = ^dir[1:0];
  assign w_junc_rise  = junction && !r_junc_d;

  tone_qualifier #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .clear(r_state != ST_JWAIT),
    .bp   (bp),
    .valid(w_tone_vld),
    .cmd  (w_tone_cmd)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ret   = r_ret;
    w_nxt_mcmd  = r_mcmd;
    w_nxt_last  = r_last;
    case (r_state)
      ST_FOLLOW: begin
        if (w_junc_rise) begin
          w_nxt_state = ST_JWAIT;
        end
      end
      ST_JWAIT: begin
        if (w_tone_vld) begin
          w_nxt_last = w_tone_cmd;
          case (w_tone_cmd)
            CMD_STOP: w_nxt_state = ST_HALT;
            CMD_REVERSE: begin
              w_nxt_state = ST_DEADTIME;
              w_nxt_ret   = ST_MANEUVER;
              w_nxt_mcmd  = CMD_REVERSE;
            end
            default: begin
              w_nxt_state = ST_MANEUVER;
              w_nxt_mcmd  = w_tone_cmd;
            end
          endcase
        end else if (r_timer == L_TO_LAST) begin
          w_nxt_last  = CMD_STRAIGHT;
          w_nxt_state = ST_MANEUVER;
          w_nxt_mcmd  = CMD_STRAIGHT;
        end
      end
      ST_DEADTIME: begin
        if (r_timer == L_DT_LAST) begin
          w_nxt_state = r_ret;
        end
      end
      ST_MANEUVER: begin
        // A reverse manoeuvre needs a second dead time before going forward again.
        if (r_timer == L_MAN_LAST) begin
          if (r_mcmd == CMD_REVERSE) begin
            w_nxt_state = ST_DEADTIME;
            w_nxt_ret   = ST_FOLLOW;
          end else begin
            w_nxt_state = ST_FOLLOW;
          end
        end
      end
      ST_COLLISION: begin
        if (!col_detect) begin
          w_nxt_state = ST_DEADTIME;
          w_nxt_ret   = ST_FOLLOW;
        end
      end
      default: w_nxt_state = r_state;
    endcase

    if (col_detect && (r_state != ST_HALT)) begin
      w_nxt_state = ST_COLLISION;
      w_nxt_ret   = ST_FOLLOW;
      w_nxt_mcmd  = CMD_NONE;
    end
  end

  // Motors-off states keep the rev bits so the bridge never flips direction while stopped.
  always_comb begin
    w_nxt_drv             = r_drv;
    w_nxt_drv.left_speed  = SPD_OFF;
    w_nxt_drv.right_speed = SPD_OFF;
    case (w_nxt_state)
      ST_FOLLOW:   w_nxt_drv = follow_pattern(dir[3:2]);
      ST_MANEUVER: w_nxt_drv = maneuver_pattern(w_nxt_mcmd);
      default:     w_nxt_drv = w_nxt_drv;
    endcase
    w_timer_run = (w_nxt_state == r_state) &&
                  (r_state inside {ST_JWAIT, ST_DEADTIME, ST_MANEUVER});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_FOLLOW;
      r_ret    <= ST_FOLLOW;
      r_mcmd   <= CMD_NONE;
      r_last   <= CMD_NONE;
      r_timer  <= '0;
      r_junc_d <= 1'b0;
      r_drv    <= '0;
    end else begin
      r_state  <= w_nxt_state;
      r_ret    <= w_nxt_ret;
      r_mcmd   <= w_nxt_mcmd;
      r_last   <= w_nxt_last;
      r_timer  <= w_timer_run ? (r_timer + L_ONE) : '0;
      r_junc_d <= junction;
      r_drv    <= w_nxt_drv;
    end
  end

  assign left_speed  = r_drv.left_speed;
  assign left_rev    = r_drv.left_rev;
  assign right_speed = r_drv.right_speed;
  assign right_rev   = r_drv.right_rev;
  assign state       = r_state;
  assign last_cmd    = r_last;

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboarded bench for drive_sequencer: a segment-plan reference model queues the expected
// registered outputs per cycle; a monitor pops and compares one entry after every clock edge.
module tb_drive_sequencer;
  import drive_pkg::*;

  localparam int DEB = 4;
  localparam int TO  = 50;
  localparam int MAN = 20;
  localparam int DT  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dir = 4'd0;
  logic       col_detect = 1'b0;
  logic       junction = 1'b0;
  logic [4:0] bp = 5'd0;
  logic [1:0] left_speed;
  logic       left_rev;
  logic [1:0] right_speed;
  logic       right_rev;
  logic [2:0] state;
  logic [2:0] last_cmd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  drive_sequencer #(
    .DEBOUNCE_CYCLES    (DEB),
    .TONE_TIMEOUT_CYCLES(TO),
    .MANEUVER_CYCLES    (MAN),
    .DEADTIME_CYCLES    (DT),
    .CNT_W              (28)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dir        (dir),
    .col_detect (col_detect),
    .junction   (junction),
    .bp         (bp),
    .left_speed (left_speed),
    .left_rev   (left_rev),
    .right_speed(right_speed),
    .right_rev  (right_rev),
    .state      (state),
    .last_cmd   (last_cmd)
  );

  // Reference model: a timed manoeuvre is a plan of segments consumed one cycle at a time.
  typedef struct {
    bit [2:0] st;
    bit [1:0] l;
    bit [1:0] r;
    bit       setrev;
    bit       rev;
    int       n;
  } seg_t;

  seg_t     plan[$];
  bit [1:0] m_l, m_r;
  bit       m_rev;
  bit [2:0] m_st, m_last;
  int       m_wait, m_run;
  bit [4:0] m_prev;
  bit       m_jprev;
  logic [11:0] exp_q[$];

  function automatic seg_t mk(bit [2:0] st, bit [1:0] l, bit [1:0] r, bit setrev, bit rev, int n);
    seg_t s;
    s.st = st; s.l = l; s.r = r; s.setrev = setrev; s.rev = rev; s.n = n;
    return s;
  endfunction

  task automatic consume();
    m_st = plan[0].st;
    m_l  = plan[0].l;
    m_r  = plan[0].r;
    if (plan[0].setrev) m_rev = plan[0].rev;
    plan[0].n = plan[0].n - 1;
    if (plan[0].n == 0) void'(plan.pop_front());
  endtask

  task automatic follow(input bit [3:0] d);
    m_st  = ST_FOLLOW;
    m_rev = 1'b0;
    case (d[3:2])
      2'b00: begin m_l = 2'b10; m_r = 2'b10; end
      2'b01: begin m_l = 2'b01; m_r = 2'b10; end
      2'b10: begin m_l = 2'b10; m_r = 2'b01; end
      default: begin m_l = 2'b00; m_r = 2'b00; end
    endcase
  endtask

  task automatic model_step(input bit r, input bit [3:0] d, input bit c, input bit j, input bit [4:0] b);
    bit rise;
    int idx;
    rise    = j && !m_jprev;
    m_jprev = j;
    if (r) begin
      plan.delete();
      m_st = ST_FOLLOW; m_l = 0; m_r = 0; m_rev = 0; m_last = 0; m_jprev = 0;
    end else if (m_st != ST_HALT && c) begin
      plan.delete();
      m_st = ST_COLLISION; m_l = 0; m_r = 0;
    end else begin
      case (m_st)
        ST_HALT: ;
        ST_COLLISION: begin
          plan.push_back(mk(ST_DEADTIME, 0, 0, 0, 0, DT));
          consume();
        end
        ST_FOLLOW: begin
          if (rise) begin
            m_st = ST_JWAIT; m_l = 0; m_r = 0; m_wait = 0; m_run = 0;
          end else begin
            follow(d);
          end
        end
        ST_JWAIT: begin
          m_wait++;
          if ($countones(b) == 1) m_run = (m_run > 0 && b == m_prev) ? m_run + 1 : 1;
          else m_run = 0;
          m_prev = b;
          if (m_run >= DEB) begin
            idx = 0;
            for (int i = 0; i < 5; i++) if (b[i]) idx = i;
            m_last = 3'(idx + 1);
            case (idx)
              0: begin m_st = ST_HALT; m_l = 0; m_r = 0; end
              4: begin
                plan.push_back(mk(ST_DEADTIME, 0, 0, 0, 0, DT));
                plan.push_back(mk(ST_MANEUVER, 2'b10, 2'b10, 1, 1, MAN));
                plan.push_back(mk(ST_DEADTIME, 0, 0, 0, 0, DT));
                consume();
              end
              1: begin plan.push_back(mk(ST_MANEUVER, 2'b10, 2'b10, 1, 0, MAN)); consume(); end
              2: begin plan.push_back(mk(ST_MANEUVER, 2'b00, 2'b10, 1, 0, MAN)); consume(); end
              default: begin plan.push_back(mk(ST_MANEUVER, 2'b10, 2'b00, 1, 0, MAN)); consume(); end
            endcase
          end else if (m_wait == TO) begin
            m_last = 3'd2;
            plan.push_back(mk(ST_MANEUVER, 2'b10, 2'b10, 1, 0, MAN));
            consume();
          end
        end
        default: begin
          if (plan.size() > 0) consume();
          else follow(d);
        end
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit [3:0] d, input bit c, input bit j, input bit [4:0] b);
    @(negedge clk);
    rst = r; dir = d; col_detect = c; junction = j; bp = b;
    model_step(r, d, c, j, b);
    exp_q.push_back({m_l, m_rev, m_r, m_rev, m_st, m_last});
  endtask

  task automatic run_n(input int n, input bit [3:0] d, input bit c, input bit j, input bit [4:0] b);
    repeat (n) cyc(1'b0, d, c, j, b);
  endtask

  always @(posedge clk) begin
    logic [11:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {left_speed, left_rev, right_speed, right_rev, state, last_cmd};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got L=%b lrev=%b R=%b rrev=%b st=%0d last=%0d want L=%b lrev=%b R=%b rrev=%b st=%0d last=%0d",
                 $time, a[11:10], a[9], a[8:7], a[6], a[5:3], a[2:0],
                 e[11:10], e[9], e[8:7], e[6], e[5:3], e[2:0]);
      end
    end
  end

  initial begin
    bit [3:0] rd;
    bit       rc, rj, rr;
    bit [4:0] rb;
    int       sel;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // line following, each direction word
    run_n(2, 4'b0000, 0, 0, 0);
    run_n(2, 4'b0100, 0, 0, 0);
    run_n(2, 4'b1000, 0, 0, 0);
    run_n(2, 4'b1111, 0, 0, 0);
    // LEFT command; junction stays high through and after the manoeuvre
    run_n(2, 4'b0000, 0, 0, 0);
    run_n(1, 4'b0000, 0, 1, 0);
    run_n(DEB, 4'b0000, 0, 1, 5'b00100);
    run_n(MAN + 8, 4'b0100, 0, 1, 0);
    run_n(3, 4'b0000, 0, 0, 0);
    // REVERSE command held
    run_n(1, 4'b0000, 0, 1, 0);
    run_n(2 * DT + MAN + 8, 4'b0000, 0, 1, 5'b10000);
    run_n(3, 4'b1000, 0, 0, 0);
    // two bands alternating: never valid, timeout to straight
    run_n(1, 4'b0000, 0, 1, 0);
    for (int i = 0; i < TO + MAN + 6; i++) run_n(1, 4'b0000, 0, 1, (i % 2 == 0) ? 5'b00010 : 5'b00110);
    run_n(3, 4'b0000, 0, 0, 0);
    // collision during a LEFT manoeuvre
    run_n(1, 4'b0000, 0, 1, 0);
    run_n(DEB, 4'b0000, 0, 1, 5'b00100);
    run_n(10, 4'b0000, 0, 0, 0);
    run_n(3, 4'b0000, 1, 0, 0);
    run_n(MAN, 4'b0100, 0, 0, 0);
    // STOP -> HALT; collision/junction ignored until reset
    run_n(1, 4'b0000, 0, 1, 0);
    run_n(DEB, 4'b0000, 0, 1, 5'b00001);
    for (int i = 0; i < 20; i++) run_n(1, 4'b0000, 1'(i % 3 == 0), 1'(i % 2), 0);
    cyc(1, 0, 0, 0, 0);
    run_n(3, 4'b1000, 0, 0, 0);

    rd = 0; rc = 0; rj = 0; rb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rj = !rj;
      if (rc) rc = ($urandom_range(0, 3) != 0);
      else rc = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 5) rb = 5'(1) << sel;
        else if (sel == 5) rb = 5'd0;
        else rb = 5'($urandom_range(0, 31));
      end
      rr = ($urandom_range(0, 149) == 0);
      cyc(rr, rd, rc, rj, rb);
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
